// File: rtl/dmem_responder.sv
// dmem_responder: latency-programmable load/store data memory behind valid/ready handshakes
// Ports: clk, reset (async, active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
// form the request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err form the response channel.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of being force-aligned.
module dmem_responder #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);
    localparam int WORDS = (2 ** DM_ADDRESS) / 4;
    localparam int NB    = DATA_W / 8;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t                  state;
    logic [3:0]              cnt;
    logic                    we_q;
    logic [2:0]              f3_q;
    logic [DM_ADDRESS-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       mem [WORDS];
    logic                    accept, go, we, illegal, err;
    logic [2:0]              f3;
    logic [DM_ADDRESS-1:0]   addr, ea;
    logic [DATA_W-1:0]       wdata, rd, ld, wd;
    logic [7:0]              b;
    logic [15:0]             h;
    logic [NB-1:0]           wm;
    assign req_ready = state == IDLE;
    assign accept    = req_valid && req_ready;
    // with LATENCY=1 the access happens on the accept edge, straight from the request inputs
    assign go    = (accept && LATENCY == 1) || (state == BUSY && cnt == 4'd0);
    assign we    = state == IDLE ? req_we : we_q;
    assign f3    = state == IDLE ? req_funct3 : f3_q;
    assign addr  = state == IDLE ? req_addr : addr_q;
    assign wdata = state == IDLE ? req_wdata : wdata_q;
    assign illegal = we ? f3 > 3'd2 : (f3 == 3'b011 || f3[2:1] == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign err = illegal || misalign;
    assign ea  = addr;
`else
    assign err = illegal;
    assign ea  = f3[1:0] == 2'b01 ? {addr[DM_ADDRESS-1:1], 1'b0} :
                 f3[1:0] == 2'b10 ? {addr[DM_ADDRESS-1:2], 2'b00} : addr;
`endif
    assign rd = mem[ea[DM_ADDRESS-1:2]];
    assign b  = rd[8*ea[1:0] +: 8];
    assign h  = rd[16*ea[1] +: 16];
    // funct3[2] selects zero extension for LBU/LHU
    assign ld = f3[1:0] == 2'b00 ? {{(DATA_W-8){!f3[2] && b[7]}}, b} :
                f3[1:0] == 2'b01 ? {{(DATA_W-16){!f3[2] && h[15]}}, h} : rd;
    assign wd = f3[1:0] == 2'b00 ? {NB{wdata[7:0]}} :
                f3[1:0] == 2'b01 ? {(NB/2){wdata[15:0]}} : wdata;
    assign wm = f3[1:0] == 2'b00 ? NB'(1) << ea[1:0] :
                f3[1:0] == 2'b01 ? NB'(3) << {ea[1], 1'b0} : '1;
    // storage is never reset; reset only blocks a pending commit
    always_ff @(posedge clk)
        if (go && we && !err && !reset)
            for (int i = 0; i < NB; i++)
                if (wm[i]) mem[ea[DM_ADDRESS-1:2]][8*i +: 8] <= wd[8*i +: 8];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY - 1);
                state   <= BUSY;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (go) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= (we || err) ? '0 : ld;
                rsp_err   <= err;
            end
            if (state == RESP && rsp_ready) begin
                state     <= IDLE;
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
